// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Bit-serial writer for a configuration flip-flop chain. Bitstream words
// arrive over a valid/ready handshake, are serialized LSB first onto
// ccff_head, and prog_clk_en marks the cycles in which the chain's gated
// programming clock should shift. Exactly CHAIN_LEN bits are shifted per
// load; unused upper bits of a partial final word are dropped.
//
// Parameters:
//   CHAIN_LEN      total configuration bits in the chain (>= 1)
//   WORD_W         width of an incoming bitstream word (>= 1)
//
// Ports:
//   prog_clk       ungated programming clock, rising-edge active
//   prog_reset     synchronous active-high reset
//   start          load request, honoured only in IDLE
//   word_data      bitstream word, bit 0 shifted first
//   word_valid     word_data is valid
//   word_ready     loader accepts a word this cycle
//   ccff_head      serial bit into the chain head
//   prog_clk_en    chain shift enable
//   ccff_tail      chain tail bit (readback only)
//   busy           load in progress
//   done           one-cycle pulse after the final bit
//   readback_ones  ones seen on ccff_tail during the last load
//
// Build option:
//   CCFF_READBACK_EN  when defined, readback_ones counts ones on ccff_tail
//                     in enabled cycles; otherwise it is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | word_ready high, waiting for the next bitstream word
// S_SHIFT | one bit per cycle onto ccff_head with prog_clk_en high
// S_DONE  | done pulse, back to idle next cycle

module ccff_chain_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic                               prog_clk,
    input  logic                               prog_reset,
    input  logic                               start,
    input  logic [WORD_W-1:0]                  word_data,
    input  logic                               word_valid,
    output logic                               word_ready,
    output logic                               ccff_head,
    output logic                               prog_clk_en,
    input  logic                               ccff_tail,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]     readback_ones
);

    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int WCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAIN_LEN - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shift_reg;
    logic [BCW-1:0]    bit_cnt;
    logic [WCW-1:0]    word_cnt;
    logic              last_bit;
    logic              last_of_word;

    // The head bit is taken straight from the shift register so it holds its
    // last value whenever the register is not shifting.
    assign ccff_head    = shift_reg[0];
    assign last_bit     = (bit_cnt == BIT_LAST);
    assign last_of_word = (word_cnt == WORD_LAST);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state       <= S_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            word_ready  <= 1'b0;
            prog_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        bit_cnt    <= '0;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (word_valid) begin
                        state       <= S_SHIFT;
                        shift_reg   <= word_data;
                        word_cnt    <= '0;
                        word_ready  <= 1'b0;
                        prog_clk_en <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    bit_cnt  <= bit_cnt + 1'b1;
                    word_cnt <= word_cnt + 1'b1;
                    // Chain end wins over word end: the rest of a partial
                    // final word is simply never shifted.
                    if (last_bit) begin
                        state       <= S_DONE;
                        prog_clk_en <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (last_of_word) begin
                        state       <= S_FETCH;
                        prog_clk_en <= 1'b0;
                        word_ready  <= 1'b1;
                    end else begin
                        shift_reg <= shift_reg >> 1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_READBACK_EN
    logic [BCW-1:0] rb_cnt;

    // Cleared only by an accepted start so the count survives past DONE.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            rb_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            rb_cnt <= '0;
        end else if (prog_clk_en && ccff_tail) begin
            rb_cnt <= rb_cnt + 1'b1;
        end
    end

    assign readback_ones = rb_cnt;
`else
    logic unused_tail;
    assign unused_tail   = ccff_tail;
    assign readback_ones = '0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
// Self-checking bench for ccff_chain_loader. A 16-bit / 8-bit instance is
// checked every cycle against a bit-queue reference model, driven by a
// vector table, hand-written reset sequence and randomized loads. A second
// 10-bit / 8-bit instance covers the partial final word.

module tb_ccff_chain_loader;

    localparam int CL = 16;
    localparam int WW = 8;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic       prog_reset = 1'b1;
    logic       start      = 1'b0;
    logic       word_valid = 1'b0;
    logic [7:0] word_data  = 8'h00;
    logic       word_ready, ccff_head, prog_clk_en, busy, done, ccff_tail;
    logic [4:0] readback_ones;
    logic [15:0] chain16 = 16'h0000;

    logic       start10 = 1'b0;
    logic       valid10 = 1'b0;
    logic [7:0] data10  = 8'h00;
    logic       ready10, head10, en10, busy10, done10;
    logic       tail10 = 1'b0;
    logic [3:0] rb10;

    // Chain model: head enters at the top, tail is bit 0.
    assign ccff_tail = chain16[0];
    always_ff @(posedge prog_clk) begin
        if (prog_clk_en) chain16 <= {ccff_head, chain16[15:1]};
    end

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .ccff_head(ccff_head), .prog_clk_en(prog_clk_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .readback_ones(readback_ones)
    );

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start10),
        .word_data(data10), .word_valid(valid10), .word_ready(ready10),
        .ccff_head(head10), .prog_clk_en(en10), .ccff_tail(tail10),
        .busy(busy10), .done(done10), .readback_ones(rb10)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of bits still owed to the chain, the number of
    // chain bits not yet fetched, and a pending done pulse.
    bit pend[$];
    int m_left = 0;
    bit m_done = 0;
    bit m_head = 0;
    int m_rb   = 0;

    function automatic bit e_en();
        return (pend.size() > 0);
    endfunction
    function automatic bit e_ready();
        return (pend.size() == 0) && (m_left > 0);
    endfunction
    function automatic bit e_head();
        return (pend.size() > 0) ? pend[0] : m_head;
    endfunction
    function automatic bit m_idle();
        return (pend.size() == 0) && (m_left == 0) && !m_done;
    endfunction

    task automatic model_update();
        bit en_c, rdy_c;
        int n;
        en_c  = e_en();
        rdy_c = e_ready();
        if (prog_reset) begin
            pend.delete();
            m_left = 0;
            m_done = 0;
            m_head = 0;
            m_rb   = 0;
        end else if (en_c) begin
            if (ccff_tail) m_rb++;
            m_head = pend.pop_front();
            if (pend.size() == 0 && m_left == 0) m_done = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (rdy_c) begin
            if (word_valid) begin
                n = (m_left < WW) ? m_left : WW;
                for (int i = 0; i < n; i++) pend.push_back(word_data[i]);
                m_left -= n;
            end
        end else if (start) begin
            m_left = CL;
            m_rb   = 0;
        end
    endtask

    task automatic check_model();
        chk("word_ready", word_ready, e_ready());
        chk("prog_clk_en", prog_clk_en, e_en());
        chk("ccff_head", ccff_head, e_head());
        chk("busy", busy, e_en() || e_ready());
        chk("done", done, m_done);
`ifdef CCFF_READBACK_EN
        chk("readback_ones", readback_ones, m_rb);
`else
        chk("readback_ones", readback_ones, 0);
`endif
    endtask

    int         en10_cnt = 0, rdy10_cnt = 0, done10_cnt = 0, done10_at = -1;
    logic [9:0] bits10 = '0;

    task automatic tick();
        model_update();
        @(posedge prog_clk);
        #1;
        cyc++;
        check_model();
        if (en10) begin
            en10_cnt++;
            bits10 = {head10, bits10[9:1]};
        end
        if (ready10) rdy10_cnt++;
        if (done10) begin
            done10_cnt++;
            done10_at = cyc;
        end
    endtask

    typedef struct {
        logic [7:0] w0;
        logic [7:0] w1;
        int         gap;
        bit         poke;
        int         exp_done;
        logic [4:0] exp_rb;
    } vec_t;

    vec_t vt[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ens, done_at, acc, cs, acc10;
        bit   accept;
        logic [15:0] got;

        vt[0] = '{8'hA5, 8'h3C, 0, 1'b0, 19, 5'd0};
        vt[1] = '{8'hA5, 8'h3C, 5, 1'b0, 24, 5'd8};
        vt[2] = '{8'hFF, 8'hFF, 0, 1'b1, 19, 5'd8};
        vt[3] = '{8'h00, 8'h00, 2, 1'b1, 21, 5'd16};

        repeat (3) tick();
        prog_reset = 1'b0;
        tick();
        chk("rst_word_ready", word_ready, 0);
        chk("rst_ccff_head", ccff_head, 0);
        chk("rst_prog_clk_en", prog_clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_readback", readback_ones, 0);

        // Vector table: two-word loads with optional gap and mid-shift start.
        for (int r = 0; r < 4; r++) begin
            start = 1'b1; word_valid = 1'b1; word_data = vt[r].w0;
            acc = 0; ens = 0; done_at = -1; got = '0;
            for (int k = 0; k < 60 && done_at < 0; k++) begin
                accept = word_ready && word_valid;
                tick();
                if (accept) acc++;
                if (prog_clk_en) begin
                    got = {ccff_head, got[15:1]};
                    ens++;
                end
                if (done) done_at = k + 1;
                word_data  = (acc == 0) ? vt[r].w0 : vt[r].w1;
                word_valid = !((k + 1) >= 10 && (k + 1) < 10 + vt[r].gap);
                start      = vt[r].poke && (k + 1 == 5);
            end
            chk($sformatf("vec%0d_done_at", r), done_at, vt[r].exp_done);
            chk($sformatf("vec%0d_enables", r), ens, 16);
            chk($sformatf("vec%0d_head_bits", r), got, {vt[r].w1, vt[r].w0});
            chk($sformatf("vec%0d_chain", r), chain16, {vt[r].w1, vt[r].w0});
`ifdef CCFF_READBACK_EN
            chk($sformatf("vec%0d_readback", r), readback_ones, vt[r].exp_rb);
`else
            chk($sformatf("vec%0d_readback", r), readback_ones, 0);
`endif
            start = 1'b0; word_valid = 1'b0;
            repeat (2) tick();
        end

        // Reset after five shifted bits, then a clean reload.
        start = 1'b1; word_valid = 1'b1; word_data = 8'h5A; ens = 0;
        for (int k = 0; k < 40 && ens < 5; k++) begin
            tick();
            start = 1'b0;
            if (prog_clk_en) ens++;
        end
        chk("rst_mid_enables_before", ens, 5);
        prog_reset = 1'b1;
        tick();
        prog_reset = 1'b0;
        chk("rst_mid_word_ready", word_ready, 0);
        chk("rst_mid_ccff_head", ccff_head, 0);
        chk("rst_mid_prog_clk_en", prog_clk_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_readback", readback_ones, 0);
        start = 1'b1; word_data = 8'hC3; ens = 0; done_at = -1;
        for (int k = 0; k < 60 && done_at < 0; k++) begin
            tick();
            start = 1'b0;
            if (prog_clk_en) ens++;
            if (done) done_at = k + 1;
        end
        chk("reload_enables", ens, 16);
        chk("reload_done_at", done_at, 19);
        word_valid = 1'b0;
        repeat (2) tick();

        // Partial final word on the 10-bit chain.
        en10_cnt = 0; rdy10_cnt = 0; done10_cnt = 0; done10_at = -1; bits10 = '0;
        start10 = 1'b1; valid10 = 1'b1; data10 = 8'hFF; acc10 = 0; cs = cyc;
        for (int k = 0; k < 40 && done10_cnt == 0; k++) begin
            accept = ready10 && valid10;
            tick();
            start10 = 1'b0;
            if (accept) acc10++;
            data10 = (acc10 == 0) ? 8'hFF : 8'hFE;
        end
        repeat (4) tick();
        valid10 = 1'b0;
        chk("c10_enables", en10_cnt, 10);
        chk("c10_head_bits", bits10, 10'h2FF);
        chk("c10_words_accepted", acc10, 2);
        chk("c10_ready_cycles", rdy10_cnt, 2);
        chk("c10_done_pulses", done10_cnt, 1);
        chk("c10_done_at", done10_at - cs, 13);
        chk("c10_busy_after", busy10, 0);
        chk("c10_readback", rb10, 0);

        // Randomized loads: random stalls, data, stray starts and rare resets.
        for (int l = 0; l < 25; l++) begin
            start = 1'b1;
            word_valid = ($urandom_range(0, 3) != 0);
            word_data  = 8'($urandom);
            tick();
            for (int k = 0; k < 300 && !m_idle(); k++) begin
                word_valid = ($urandom_range(0, 3) != 0);
                word_data  = 8'($urandom);
                start      = ($urandom_range(0, 9) == 0);
                prog_reset = ($urandom_range(0, 199) == 0);
                tick();
            end
            prog_reset = 1'b0; start = 1'b0;
            if (!m_idle()) chk("rand_load_timeout", 1, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bit-serial configuration-chain writer: drives the `ccff_head` end of a programming chain and observes its `ccff_tail` end. It accepts bitstream words over a valid/ready interface, serializes them one bit per cycle onto `ccff_head`, and produces `prog_clk_en`. `prog_clk_en` feeds the clock gate generating the chain's gated `prog_clk`, so the chain shifts only on cycles the loader marks valid. It sits between the bitstream source (SPI/JTAG front end) and the fabric's `ccff_head`/`ccff_tail` pins.

## Interface
Parameters:
- `CHAIN_LEN`, default 16: total configuration bits in the chain; must be ≥ 1.
- `WORD_W`, default 8: width of the input bitstream word; must be ≥ 1.

Ports:
- `prog_clk`  in  1  programming clock (ungated); all state updates on its rising edge.
- `prog_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `word_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `ccff_head`  out  1  serial bit driven into the chain head.
- `prog_clk_en`  out  1  chain shift enable; chain captures `ccff_head` at the end of each cycle where this is 1.
- `ccff_tail`  in  1  chain tail output, sampled in cycles where `prog_clk_en`=1.
- `busy`  out  1  load in progress (FETCH or SHIFT).
- `done`  out  1  one-cycle pulse after the final bit.
- `readback_ones`  out  clog2(CHAIN_LEN+1)  count of ones shifted out of `ccff_tail` during the last load.

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- **IDLE**: `start`=1 moves to FETCH. The bit counter and the readback counter clear.
- **FETCH**: `word_ready`=1, `prog_clk_en`=0.
  - `word_valid`&&`word_ready` latches `word_data` into the shift register.
  - Next state is SHIFT. Stays in FETCH while `word_valid`=0.
- **SHIFT**: `ccff_head` = shift_reg[0], `prog_clk_en`=1, `word_ready`=0.
  - Each cycle the register shifts right one bit and the bit counter increments.
  - Leaves SHIFT after WORD_W bits or when the bit counter reaches CHAIN_LEN, whichever comes first.
  - Goes to DONE if the counter equals CHAIN_LEN, else back to FETCH.
  - When CHAIN_LEN is not a multiple of WORD_W, the unused upper bits of the final word are discarded.
- **DONE**: `done`=1 for one cycle, `prog_clk_en`=0, then IDLE.
- Words needed per load = ceil(CHAIN_LEN/WORD_W).
- The first bit shifted ends at the tail-most chain position after a full load.
- `start` outside IDLE is ignored; it does not restart or queue.
- `busy`=1 in FETCH and SHIFT only.
- `ccff_head` holds its last value when `prog_clk_en`=0. This is don't-care for the chain.

## Timing
- Reset values: `word_ready`=0, `ccff_head`=0, `prog_clk_en`=0, `busy`=0, `done`=0, `readback_ones`=0; state IDLE.
- `start` at cycle t → `word_ready`=1 at t+1.
- Word accepted at cycle a → bits appear on `ccff_head` with `prog_clk_en`=1 at cycles a+1 … a+WORD_W.
- Each word costs one FETCH bubble minimum. A full load with words always valid takes ceil(CHAIN_LEN/WORD_W)·(WORD_W+1) cycles from the first `word_ready`, truncated for a partial last word.
- `done` asserts the cycle after the last `prog_clk_en`=1 cycle.
- Reset mid-operation takes effect at the next edge. The load is abandoned and chain contents are undefined; a fresh `start` reloads all CHAIN_LEN bits.
- The bit counter never exceeds CHAIN_LEN.
- `prog_clk_en`=1 for exactly CHAIN_LEN cycles per completed load.

## Configuration
- `CCFF_READBACK_EN`, defined:
  - In every cycle with `prog_clk_en`=1, `ccff_tail`=1 increments `readback_ones`.
  - `readback_ones` clears on an accepted `start` and holds after DONE.
  - After two back-to-back loads, it equals the popcount of the first load's bitstream.
- `CCFF_READBACK_EN`, undefined: `readback_ones` is tied to 0, no counter logic is present, and `ccff_tail` is unused.

## Test plan
- CHAIN_LEN=16, WORD_W=8, words 0xA5 then 0x3C always valid → `ccff_head` bit sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 under `prog_clk_en`. 16 enable cycles total, one bubble between words, `done` one cycle after the last bit.
- Same config, `word_valid` low for 5 cycles before the second word → `prog_clk_en`=0 for those cycles, still 16 enables total, `done` delayed by 5 cycles.
- CHAIN_LEN=10, WORD_W=8, words 0xFF, 0xFF → 2 words accepted, only 2 bits of the second shifted, 10 enables, `word_ready` never reasserts after the second word.
- `prog_reset` after 5 shifted bits → next cycle all outputs at reset values. A new `start` then yields 16 enables and `done`.
- `start` pulsed during SHIFT → no effect: enable count and `done` timing unchanged.
- With `CCFF_READBACK_EN` and a chain model attached: load 0xFFFF, then load 0x0000 → `readback_ones`=16. Without the macro → `readback_ones`=0 throughout.
